neuron_spike_ctrl: RTL

//  Downstream of the 8-input neuron. Converts a threshold crossing (non-zero

---
 rtl/snn_pkg.sv | 23 ++
 rtl/spike_evt_fifo.sv | 54 +++++
 rtl/neuron_spike_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared FSM state encoding and event-width helper for the spike controller.
// Event width grows by the timestamp field when SPIKE_TIMESTAMP_EN is defined.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        REFRACT = 2'd2
    } state_t;

    localparam bit TS_EN =
`ifdef SPIKE_TIMESTAMP_EN
        1'b1;
`else
        1'b0;
`endif

    function automatic int unsigned evt_width(input int unsigned vwidth,
                                              input int unsigned tsw);
        return vwidth + (TS_EN ? tsw : 0);
    endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous event FIFO without fall-through; a push that meets a full FIFO
// with no pop in the same cycle is dropped and sets the sticky overflow flag.
module spike_evt_fifo #(
    parameter int unsigned width = 22,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] rd_data,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || rd_en);

    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (rd_en)
                rptr <= rptr + 1'b1;
            if (push && !wr_en)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/neuron_spike_ctrl.sv
// Spike FSM (IDLE/FIRE/REFRACT), saturating spike counter and event queue.
// Define SPIKE_TIMESTAMP_EN to prepend a free-running timestamp to each event.
module neuron_spike_ctrl
    import snn_pkg::*;
#(
    parameter int unsigned p_vwidth = 22,
    parameter int unsigned p_refw   = 8,
    parameter int unsigned p_depth  = 4,
    parameter int unsigned p_cntw   = 16,
    parameter int unsigned p_tsw    = 16
) (
    input  logic                                 i_base_clk,
    input  logic                                 i_rst_n,
    input  logic [p_vwidth-1:0]                  i_neuron_out,
    input  logic [p_refw-1:0]                    i_refractory,
    output logic                                 o_spike,
    output logic                                 o_inhibit,
    output logic                                 o_evt_valid,
    input  logic                                 i_evt_ready,
    output logic [evt_width(p_vwidth,p_tsw)-1:0] o_evt_data,
    output logic [p_cntw-1:0]                    o_spike_cnt,
    output logic                                 o_overflow
);

    localparam int unsigned EW = evt_width(p_vwidth, p_tsw);

    state_t              state;
    logic [p_vwidth-1:0] amp;
    logic [p_refw-1:0]   rcnt;
    logic [EW-1:0]       evt;
    logic                push;
    logic                pop;
    logic                empty;

    always_ff @(posedge i_base_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            amp         <= '0;
            rcnt        <= '0;
            o_spike     <= 1'b0;
            o_inhibit   <= 1'b0;
            o_spike_cnt <= '0;
        end else begin
            o_spike <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_neuron_out != '0) begin
                        state     <= FIRE;
                        amp       <= i_neuron_out;
                        o_spike   <= 1'b1;
                        o_inhibit <= 1'b1;
                    end
                end
                FIRE: begin
                    if (o_spike_cnt != '1)
                        o_spike_cnt <= o_spike_cnt + 1'b1;
                    rcnt <= i_refractory;
                    if (i_refractory != '0) begin
                        state <= REFRACT;
                    end else begin
                        state     <= IDLE;
                        o_inhibit <= 1'b0;
                    end
                end
                REFRACT: begin
                    // Counter enters at R and leaves on 1, giving exactly R cycles.
                    rcnt <= rcnt - 1'b1;
                    if (rcnt == p_refw'(1)) begin
                        state     <= IDLE;
                        o_inhibit <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_inhibit <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPIKE_TIMESTAMP_EN
    logic [p_tsw-1:0] ts;

    always_ff @(posedge i_base_clk) begin
        if (!i_rst_n)
            ts <= '0;
        else
            ts <= ts + 1'b1;
    end

    assign evt = {ts, amp};
`else
    assign evt = amp;
`endif

    assign push        = (state == FIRE);
    assign o_evt_valid = !empty;
    assign pop         = o_evt_valid && i_evt_ready;

    spike_evt_fifo #(
        .width (EW),
        .depth (p_depth)
    ) u_fifo (
        .clk      (i_base_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .pop      (pop),
        .wr_data  (evt),
        .rd_data  (o_evt_data),
        .empty    (empty),
        .overflow (o_overflow)
    );

endmodule
